// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_pkg: shared FSM states, parity modes and parity check for the serial frame receiver
package serial_frame_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_EVEN = 2'b01;
  localparam logic [1:0] MODE_ODD  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;
  function automatic logic parity_ok(input logic payload_xor, input logic p, input logic [1:0] m);
    return (payload_xor ^ p) == (m == MODE_ODD);
  endfunction
endpackage

// File: rtl/frame_hold_reg.sv
// frame_hold_reg: one-entry valid/ready holding register that drops and flags frames arriving while full
module frame_hold_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         overrun
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= load && valid && !ready;
      if (load && (!valid || ready)) begin
        dout  <= din;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start-bit framed LSB-first deserializer with optional parity and a one-word output buffer
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sin,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              par_err,
  output logic              overrun
);
  localparam int CW = $clog2(DATA_W);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [1:0] mode_q, mode_n;
  logic commit, par_mode, perr;
  assign par_mode = mode_q == MODE_EVEN || mode_q == MODE_ODD;
  assign perr = state == PARITY && !parity_ok(^shreg, sin, mode_q);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      mode_q <= MODE_NONE;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shreg  <= shreg_n;
      mode_q <= mode_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    mode_n  = mode_q;
    commit  = 1'b0;
    unique case (state)
      IDLE: if (en && sin) begin
        state_n = DATA;
        cnt_n   = '0;
        mode_n  = mode;
      end
      DATA: if (!en) state_n = IDLE;
      else begin
        shreg_n[cnt] = sin;
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(DATA_W - 1)) begin
          cnt_n   = '0;
          state_n = par_mode ? PARITY : IDLE;
          commit  = !par_mode;
        end
      end
      PARITY: begin
        state_n = IDLE;
        commit  = en;
      end
      default: state_n = IDLE;
    endcase
  end
  frame_hold_reg #(.W(DATA_W + 1)) hold (
    .clk(clk),
    .reset(reset),
    .load(commit),
    .din({perr, shreg_n}),
    .ready(ready),
    .dout({par_err, data_out}),
    .valid(valid),
    .overrun(overrun)
  );
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed checks of framing, parity, buffering, abort and reset behaviour
module tb_serial_frame_rx;
  logic clk = 0, reset = 0, en = 0, sin = 0, ready = 0;
  logic [1:0] mode = 2'b00;
  logic [7:0] data_out;
  logic valid, par_err, overrun;
  int checks = 0, errors = 0;

  serial_frame_rx #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .sin(sin), .mode(mode),
    .data_out(data_out), .valid(valid), .ready(ready),
    .par_err(par_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic p);
    sin = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      sin = d[i];
      tick();
    end
    if (use_par) begin
      sin = p;
      tick();
    end
    sin = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    checks++; if ({par_err, overrun} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {par_err, overrun}); end
    tick();
    reset = 1'b0;
    en = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] d;
    d = 8'hA5;
    mode = 2'b00;
    ready = 1'b1;
    sin = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      sin = d[i];
      tick();
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_early: valid got %b want 0 after edge 7", valid); end
    sin = d[7];
    tick();
    sin = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", data_out); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b want 0", par_err); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_accept: valid got %b want 0", valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_hold: data got %h want a5", data_out); end
  endtask

  task automatic test_parity();
    ready = 1'b1;
    mode = 2'b01;
    send_frame(8'hA5, 1'b1, 1'b0);
    checks++; if ({valid, par_err} !== 2'b10) begin errors++; $display("FAIL even_ok: valid,perr got %b want 10", {valid, par_err}); end
    tick();
    send_frame(8'hA5, 1'b1, 1'b1);
    checks++; if ({valid, par_err} !== 2'b11) begin errors++; $display("FAIL even_bad: valid,perr got %b want 11", {valid, par_err}); end
    tick();
    mode = 2'b10;
    send_frame(8'hA5, 1'b1, 1'b1);
    checks++; if ({valid, par_err} !== 2'b10) begin errors++; $display("FAIL odd_ok: valid,perr got %b want 10", {valid, par_err}); end
    tick();
    send_frame(8'h81, 1'b1, 1'b0);
    checks++; if ({valid, par_err, data_out} !== {2'b11, 8'h81}) begin errors++; $display("FAIL odd_bad: got %b want 1181", {valid, par_err, data_out}); end
    tick();
    mode = 2'b11;
    send_frame(8'h01, 1'b0, 1'b0);
    checks++; if ({valid, par_err, data_out} !== {2'b10, 8'h01}) begin errors++; $display("FAIL rsvd_none: got %b want 10 01", {valid, par_err, data_out}); end
    tick();
    mode = 2'b00;
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    checks++; if ({valid, overrun, data_out} !== {2'b10, 8'h3C}) begin errors++; $display("FAIL b2b_first: got %b want 10 3c", {valid, overrun, data_out}); end
    send_frame(8'hC3, 1'b0, 1'b0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    checks++; if ({valid, data_out} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL b2b_keep: got %b want 1 3c", {valid, data_out}); end
    tick();
    checks++; if ({valid, overrun} !== 2'b10) begin errors++; $display("FAIL b2b_pulse: valid,overrun got %b want 10", {valid, overrun}); end
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: valid got %b want 0", valid); end
  endtask

  task automatic test_accept_and_load();
    logic [7:0] d;
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0);
    d = 8'h22;
    sin = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      sin = d[i];
      if (i == 7) ready = 1'b1;
      tick();
    end
    sin = 1'b0;
    checks++; if ({valid, overrun, data_out} !== {2'b10, 8'h22}) begin errors++; $display("FAIL swap: got %b want 10 22", {valid, overrun, data_out}); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL swap_drain: valid got %b want 0", valid); end
  endtask

  task automatic test_abort_and_mode();
    logic [7:0] d;
    ready = 1'b1;
    sin = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      sin = i[0];
      tick();
    end
    en = 1'b0;
    sin = 1'b0;
    tick();
    en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if ({valid, overrun} !== 2'b00) begin errors++; $display("FAIL abort_quiet: valid,overrun got %b want 00", {valid, overrun}); end
    send_frame(8'h5A, 1'b0, 1'b0);
    checks++; if ({valid, overrun, data_out} !== {2'b10, 8'h5A}) begin errors++; $display("FAIL abort_next: got %b want 10 5a", {valid, overrun, data_out}); end
    tick();
    d = 8'h5A;
    mode = 2'b01;
    sin = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      sin = d[i];
      if (i == 2) mode = 2'b00;
      tick();
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mode_latched: valid got %b want 0 before parity", valid); end
    sin = 1'b1;
    tick();
    sin = 1'b0;
    checks++; if ({valid, par_err, data_out} !== {2'b11, 8'h5A}) begin errors++; $display("FAIL mode_parity: got %b want 11 5a", {valid, par_err, data_out}); end
    tick();
  endtask

  task automatic test_async_reset();
    ready = 1'b0;
    mode = 2'b01;
    send_frame(8'hA5, 1'b1, 1'b1);
    checks++; if ({valid, par_err} !== 2'b11) begin errors++; $display("FAIL rst_pre: valid,perr got %b want 11", {valid, par_err}); end
    mode = 2'b00;
    sin = 1'b1;
    tick();
    sin = 1'b1;
    tick();
    tick();
    #3;
    reset = 1'b1;
    sin = 1'b0;
    #1;
    checks++; if ({valid, par_err, overrun, data_out} !== 11'b0) begin errors++; $display("FAIL rst_async: got %b want all 0", {valid, par_err, overrun, data_out}); end
    #1;
    reset = 1'b0;
    ready = 1'b1;
    tick();
    send_frame(8'hC3, 1'b0, 1'b0);
    checks++; if ({valid, par_err, data_out} !== {2'b10, 8'hC3}) begin errors++; $display("FAIL rst_after: got %b want 10 c3", {valid, par_err, data_out}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_accept_and_load();
    test_abort_and_mode();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receive-side endpoint for the single-wire serial link driven by the mod1-style producer.
- Takes a start-bit-framed, LSB-first bit stream, one bit per clk, with an optional parity bit selected by a 2-bit mode bus.
- Deserializes each frame into a DATA_W word and presents it on a one-entry valid/ready output buffer.
- Sits beside mod2 in the top level and shares the same enable (A), serial (B) and bus1-style mode nets.

Parameters:
- DATA_W, 8: payload bits per frame; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  link enable. 0 aborts any frame in progress.
- sin  input  1  serial data, sampled every rising clk edge.
- mode  input  2  parity mode:
  - 00: none
  - 01: even
  - 10: odd
  - 11: reserved, treated as none.
- data_out  output  DATA_W  received payload; valid only while valid=1.
- valid  output  1  output buffer holds a word.
- ready  input  1  consumer accepts the word when valid&&ready at a clk edge.
- par_err  output  1  parity mismatch for the word in data_out; qualified by valid.
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the buffer was full.

Behaviour:
- Reset (async assert, sync deassert handled by the top level):
  - FSM=IDLE, bit counter=0, shift register=0.
  - data_out=0, valid=0, par_err=0, overrun=0.
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - en=1 && sin=1 is the start bit: latch mode into mode_q, counter=0, go to DATA.
  - Otherwise stay in IDLE.
- DATA:
  - Each cycle, sin is written to shreg[counter] and counter increments.
  - When counter==DATA_W-1: if mode_q is 01/10, go to PARITY; otherwise commit the frame and return to IDLE.
- PARITY:
  - Sample sin as the parity bit, commit, return to IDLE.
  - Error conditions:
    - even mode: XOR(payload)^p != 0
    - odd mode: XOR(payload)^p != 1
- Latency, with the start bit sampled at edge t:
  - Data bits are sampled at t+1..t+DATA_W; parity at t+DATA_W+1.
  - valid rises after edge t+DATA_W (no parity) or t+DATA_W+1 (parity).
- Back-to-back frames: the next start bit is accepted in the cycle immediately after the last data or parity bit. No idle gap is required.
- Commit rules, evaluated at the commit edge:
  - Buffer empty, or valid&&ready this edge: load data_out and par_err, valid=1.
  - valid=1 && ready=0: frame dropped, overrun=1 for one cycle; data_out, par_err and valid unchanged.
- Acceptance: valid&&ready with no commit clears valid next cycle. data_out holds its last value.
- Abort: en=0 while in DATA or PARITY returns to IDLE next edge. Partial frame discarded, no overrun, output buffer untouched.
- mode changes mid-frame are ignored; mode_q governs the frame.
- reset mid-frame or mid-hold clears everything immediately, including a pending word.
- par_err is 0 whenever the committed frame had no parity.

Decomposition:
- Package serial_frame_pkg:
  - state enum (IDLE/DATA/PARITY)
  - mode localparams MODE_NONE=2'b00, MODE_EVEN=2'b01, MODE_ODD=2'b10, MODE_RSVD=2'b11
  - a parity_ok function.
- Sub-module frame_hold_reg (DATA_W+1 bits: payload plus par_err):
  - one-entry valid/ready holding register with load/accept/overrun logic
  - instantiated once.
- Shift register, counter and FSM stay in serial_frame_rx.

Test Plan:
- DATA_W=8, mode=00, ready=1, start at edge 0, bits of 0xA5 LSB first -> valid=1 after edge 8, data_out=0xA5, par_err=0, valid drops next cycle.
- mode=01, payload 0xA5 (four ones) with p=0 -> par_err=0. Repeat with p=1 -> par_err=1. mode=10 with p=1 -> par_err=0.
- ready=0, two back-to-back frames 0x3C then 0xC3 -> data_out stays 0x3C; overrun pulses exactly one cycle at the second commit. Raise ready -> valid clears.
- Buffer holding 0x11 with ready=1 on the same edge a frame 0x22 commits -> data_out=0x22, valid stays 1, overrun=0.
- en dropped after 4 data bits, then a full 0x5A frame -> only 0x5A delivered, no overrun. Flip mode mid-frame -> no effect on that frame.
- Assert reset asynchronously mid-frame and while valid=1 -> all outputs 0 immediately. Next frame after release received correctly.
